// File: rtl/bcd_clk_pkg.sv
// Shared encodings and constants for the HH:MM:SS digit sequencer.
// Digit indices, modes, sequencer states and BCD limits.
package bcd_clk_pkg;

  localparam int IDX_S0 = 0;
  localparam int IDX_S1 = 1;
  localparam int IDX_M0 = 2;
  localparam int IDX_M1 = 3;
  localparam int IDX_H0 = 4;
  localparam int IDX_H1 = 5;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_SET_H = 2'b01,
    MODE_SET_M = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_IDLE  = 2'b01,
    ST_PULSE = 2'b10
  } state_e;

  localparam logic [3:0] BCD_9 = 4'd9;
  localparam logic [3:0] BCD_5 = 4'd5;
  localparam logic [3:0] BCD_2 = 4'd2;
  localparam logic [3:0] BCD_3 = 4'd3;

  // Illegal digit codes take the units-9 wrap path.
  function automatic logic [3:0] bcd_sat(
    input logic [3:0] d
  );
    return (d > BCD_9) ? BCD_9 : d;
  endfunction

  function automatic mode_e next_mode(
    input mode_e m
  );
    mode_e r;
    unique case (m)
      MODE_RUN:   r = MODE_SET_H;
      MODE_SET_H: r = MODE_SET_M;
      default:    r = MODE_RUN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One-step advance decision for a two-digit BCD field.
// Units always enabled; at max tens (and non-wrapping units) cleared.
module bcd_field_step
  import bcd_clk_pkg::*;
(
  input  logic [3:0] U,
  input  logic [3:0] T,
  input  logic       step_in,
  input  logic [3:0] tens_max,
  input  logic [3:0] units_at_max,
  output logic [1:0] en,
  output logic [1:0] clr_n,
  output logic       carry
);

  logic [3:0] u;
  logic [3:0] t;

  always_comb begin
    u     = bcd_sat(U);
    t     = bcd_sat(T);
    en    = 2'b00;
    clr_n = 2'b11;
    carry = 1'b0;
    if (step_in) begin
      en[0] = 1'b1;
      if (t >= tens_max && u >= units_at_max) begin
        carry    = 1'b1;
        clr_n[1] = 1'b0;
        // A units digit sitting on 9 wraps by itself.
        if (U != BCD_9) clr_n[0] = 1'b0;
      end else if (u == BCD_9) begin
        if (t < tens_max) en[1] = 1'b1;
        else clr_n[1] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// HH:MM:SS sequencer: turns tick/mode/adj events into
// one-cycle per-digit enable and clear pulses.
module time_set_ctrl
  import bcd_clk_pkg::*;
#(
  parameter bit ADJ_CARRY  = 1'b0,
  parameter bit SET_FREEZE = 1'b1
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick,
  input  logic       mode,
  input  logic       adj,
  input  logic [3:0] S0,
  input  logic [3:0] S1,
  input  logic [3:0] M0,
  input  logic [3:0] M1,
  input  logic [3:0] H0,
  input  logic [3:0] H1,
  output logic [5:0] EN,
  output logic [5:0] nCLR,
  output logic [1:0] set_mode,
  output logic       busy
);

  state_e state;
  mode_e  mode_q;

  logic run;
  logic ev_mode;
  logic ev_adj;
  logic ev_tick;
  logic s_step;
  logic m_step;
  logic h_step;

  logic [1:0] s_en;
  logic [1:0] s_clr;
  logic [1:0] m_en;
  logic [1:0] m_clr;
  logic [1:0] h_en;
  logic [1:0] h_clr;
  logic       s_carry;
  logic       m_carry;
  logic       h_carry;

  assign set_mode = mode_q;

  // Events are mutually exclusive after priority masking.
  always_comb begin
    run     = (mode_q == MODE_RUN);
    ev_mode = mode;
    ev_adj  = adj & ~run & ~mode;
    ev_tick = tick & (run | ~SET_FREEZE) & ~mode & ~ev_adj;
    s_step  = ev_tick;
    m_step  = (ev_tick & s_carry)
            | (ev_adj & (mode_q == MODE_SET_M));
    h_step  = (ev_tick & m_carry)
            | (ev_adj & (mode_q == MODE_SET_H))
            | (ev_adj & (mode_q == MODE_SET_M)
               & m_carry & ADJ_CARRY);
  end

  bcd_field_step u_sec (
    .U            (S0),
    .T            (S1),
    .step_in      (s_step),
    .tens_max     (BCD_5),
    .units_at_max (BCD_9),
    .en           (s_en),
    .clr_n        (s_clr),
    .carry        (s_carry)
  );

  bcd_field_step u_min (
    .U            (M0),
    .T            (M1),
    .step_in      (m_step),
    .tens_max     (BCD_5),
    .units_at_max (BCD_9),
    .en           (m_en),
    .clr_n        (m_clr),
    .carry        (m_carry)
  );

  bcd_field_step u_hr (
    .U            (H0),
    .T            (H1),
    .step_in      (h_step),
    .tens_max     (BCD_2),
    .units_at_max (BCD_3),
    .en           (h_en),
    .clr_n        (h_clr),
    .carry        (h_carry)
  );

  always_ff @(posedge CP) begin
    if (CR) begin
      state  <= ST_INIT;
      mode_q <= MODE_RUN;
      EN     <= 6'b000000;
      nCLR   <= 6'b000000;
      busy   <= 1'b0;
    end else begin
      EN   <= 6'b000000;
      nCLR <= 6'b111111;
      busy <= 1'b0;
      unique case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (ev_mode | ev_adj | ev_tick) begin
            state <= ST_PULSE;
            busy  <= 1'b1;
            unique case (1'b1)
              ev_mode: begin
                mode_q <= next_mode(mode_q);
                if (mode_q == MODE_SET_M) begin
                  nCLR[IDX_S0] <= 1'b0;
                  nCLR[IDX_S1] <= 1'b0;
                end
              end
              default: begin
                EN   <= {h_en, m_en, s_en};
                nCLR <= {h_clr, m_clr, s_clr};
              end
            endcase
          end
        end
        ST_PULSE: state <= ST_IDLE;
        default:  state <= ST_INIT;
      endcase
    end
  end

  logic unused_carry;
  assign unused_carry = h_carry;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with externally driven digits.
// Each task drives one scenario and checks the pulse it expects.
module tb_time_set_ctrl;

  logic       CP;
  logic       CR;
  logic       tick;
  logic       mode;
  logic       adj;
  logic [3:0] S0, S1, M0, M1, H0, H1;
  logic [5:0] EN;
  logic [5:0] nCLR;
  logic [1:0] set_mode;
  logic       busy;

  int total;
  int bad;

  time_set_ctrl #(
    .ADJ_CARRY  (1'b0),
    .SET_FREEZE (1'b1)
  ) dut (
    .CP       (CP),
    .CR       (CR),
    .tick     (tick),
    .mode     (mode),
    .adj      (adj),
    .S0       (S0),
    .S1       (S1),
    .M0       (M0),
    .M1       (M1),
    .H0       (H0),
    .H1       (H1),
    .EN       (EN),
    .nCLR     (nCLR),
    .set_mode (set_mode),
    .busy     (busy)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic set_time(
    input logic [3:0] h1, h0, m1, m0, s1, s0
  );
    H1 = h1; H0 = h0; M1 = m1;
    M0 = m0; S1 = s1; S0 = s0;
  endtask

  task automatic fire(input logic t_i, m_i, a_i);
    @(negedge CP);
    tick = t_i; mode = m_i; adj = a_i;
    @(posedge CP); #1;
    tick = 1'b0; mode = 1'b0; adj = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CP); #1;
  endtask

  task automatic test_reset();
    CR = 1'b1;
    next_cycle();
    next_cycle();
    total++;
    if (nCLR !== 6'b000000) begin
      bad++;
      $display("FAIL rst_nclr got %b want %b", nCLR, 6'b0);
    end
    total++;
    if (EN !== 6'b000000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_en got %b/%b want 0/0", EN, busy);
    end
    total++;
    if (set_mode !== 2'b00) begin
      bad++;
      $display("FAIL rst_mode got %b want 00", set_mode);
    end
    @(negedge CP);
    CR = 1'b0;
    #1;
    total++;
    if (nCLR !== 6'b000000) begin
      bad++;
      $display("FAIL init_nclr got %b want %b", nCLR, 6'b0);
    end
    next_cycle();
    total++;
    if (nCLR !== 6'h3F || EN !== 6'b0) begin
      bad++;
      $display("FAIL idle_out got %b/%b want 111111/000000",
               nCLR, EN);
    end
  endtask

  task automatic test_tick_units();
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd8);
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (EN !== 6'b000001 || nCLR !== 6'h3F || busy !== 1'b1) begin
      bad++;
      $display("FAIL units got %b/%b/%b want 000001/111111/1",
               EN, nCLR, busy);
    end
    next_cycle();
    total++;
    if (EN !== 6'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL units_end got %b/%b want 0/0", EN, busy);
    end
  endtask

  task automatic test_tick_carry();
    set_time(4'd1, 4'd2, 4'd5, 4'd9, 4'd5, 4'd9);
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (EN !== 6'b010101 || nCLR !== 6'b110101) begin
      bad++;
      $display("FAIL carry59 got %b/%b want 010101/110101",
               EN, nCLR);
    end
    next_cycle();
    set_time(4'd1, 4'd2, 4'd0, 4'd9, 4'd5, 4'd9);
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (EN !== 6'b001101 || nCLR !== 6'b111101) begin
      bad++;
      $display("FAIL carry09 got %b/%b want 001101/111101",
               EN, nCLR);
    end
    next_cycle();
  endtask

  task automatic test_tick_wrap();
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (EN !== 6'b010101 || nCLR !== 6'b000101) begin
      bad++;
      $display("FAIL wrap24 got %b/%b want 010101/000101",
               EN, nCLR);
    end
    next_cycle();
  endtask

  task automatic test_illegal();
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd12);
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (EN !== 6'b000011 || nCLR !== 6'h3F) begin
      bad++;
      $display("FAIL illegal got %b/%b want 000011/111111",
               EN, nCLR);
    end
    next_cycle();
  endtask

  task automatic test_adj_run();
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd8);
    fire(1'b0, 1'b0, 1'b1);
    total++;
    if (busy !== 1'b0 || EN !== 6'b0) begin
      bad++;
      $display("FAIL adj_run got %b/%b want 0/0", busy, EN);
    end
  endtask

  task automatic test_back_to_back();
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd8);
    fire(1'b1, 1'b0, 1'b0);
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
    total++;
    if (busy !== 1'b0 || EN !== 6'b0) begin
      bad++;
      $display("FAIL drop_pulse got %b/%b want 0/0", busy, EN);
    end
    next_cycle();
    total++;
    if (busy !== 1'b0 || EN !== 6'b0) begin
      bad++;
      $display("FAIL drop_late got %b/%b want 0/0", busy, EN);
    end
  endtask

  task automatic test_set_h();
    fire(1'b1, 1'b1, 1'b0);
    total++;
    if (set_mode !== 2'b01 || EN !== 6'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL to_set_h got %b/%b/%b want 01/000000/1",
               set_mode, EN, busy);
    end
    next_cycle();
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b0 || EN !== 6'b0) begin
      bad++;
      $display("FAIL freeze got %b/%b want 0/0", busy, EN);
    end
    set_time(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
    fire(1'b1, 1'b0, 1'b1);
    total++;
    if (EN !== 6'b110000 || nCLR !== 6'h3F) begin
      bad++;
      $display("FAIL adj_h09 got %b/%b want 110000/111111",
               EN, nCLR);
    end
    next_cycle();
    set_time(4'd2, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0);
    fire(1'b0, 1'b0, 1'b1);
    total++;
    if (EN !== 6'b010000 || nCLR !== 6'b001111) begin
      bad++;
      $display("FAIL adj_h23 got %b/%b want 010000/001111",
               EN, nCLR);
    end
    next_cycle();
  endtask

  task automatic test_set_m();
    fire(1'b0, 1'b1, 1'b0);
    total++;
    if (set_mode !== 2'b10) begin
      bad++;
      $display("FAIL to_set_m got %b want 10", set_mode);
    end
    next_cycle();
    set_time(4'd1, 4'd2, 4'd5, 4'd9, 4'd3, 4'd0);
    fire(1'b0, 1'b0, 1'b1);
    total++;
    if (EN !== 6'b000100 || nCLR !== 6'b110111) begin
      bad++;
      $display("FAIL adj_m59 got %b/%b want 000100/110111",
               EN, nCLR);
    end
    next_cycle();
    fire(1'b0, 1'b1, 1'b0);
    total++;
    if (set_mode !== 2'b00 || nCLR !== 6'b111100 || EN !== 6'b0)
    begin
      bad++;
      $display("FAIL leave_m got %b/%b/%b want 00/111100/000000",
               set_mode, nCLR, EN);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_pulse();
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd8);
    fire(1'b0, 1'b1, 1'b0);
    CR = 1'b1;
    next_cycle();
    total++;
    if (nCLR !== 6'b0 || set_mode !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got %b/%b/%b want 000000/00/0",
               nCLR, set_mode, busy);
    end
    @(negedge CP);
    CR = 1'b0;
    next_cycle();
    fire(1'b1, 1'b0, 1'b0);
    total++;
    if (EN !== 6'b000001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_rst got %b/%b want 000001/1", EN, busy);
    end
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    CR    = 1'b1;
    tick  = 1'b0;
    mode  = 1'b0;
    adj   = 1'b0;
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_tick_units();
    test_tick_carry();
    test_tick_wrap();
    test_illegal();
    test_adj_run();
    test_back_to_back();
    test_set_h();
    test_set_m();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
